// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART byte-buffering bridge.
package uart_fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    TX_IDLE,
    TX_HOLD
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_MASK
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through circular FIFO with registered full/empty flags and level.
// Push when full and pop when empty are ignored; head reads zero when empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LEVEL_W-1:0] count;
  logic [LEVEL_W-1:0] count_next;
  logic               full_q;
  logic               empty_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full_q  <= (count_next == LEVEL_W'(DEPTH));
      empty_q <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty_q ? '0 : mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count;

endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-side TX/RX byte FIFOs in front of a UART core; UART write one cycle after a host push at best,
// RX capture stalls (byte left in the UART) while the RX FIFO is full.
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [BYTE_W-1:0]  tx_data_i,
  input  logic               tx_wr_i,
  output logic               tx_ready_o,
  output logic [BYTE_W-1:0]  rx_data_o,
  output logic               rx_valid_o,
  input  logic               rx_rd_i,
  output logic [LEVEL_W-1:0] tx_level_o,
  output logic [LEVEL_W-1:0] rx_level_o,
  output logic               uart_wr_o,
  output logic [BYTE_W-1:0]  uart_tx_data_o,
  input  logic               uart_busy_i,
  output logic               uart_rd_o,
  input  logic [BYTE_W-1:0]  uart_rx_data_i,
  input  logic               uart_valid_i
);

  tx_state_t tx_state, tx_state_next;
  rx_state_t rx_state, rx_state_next;

  logic tx_pop, tx_full, tx_empty;
  logic rx_push, rx_full, rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk       (clk),
    .reset_i   (reset_i),
    .push      (tx_wr_i),
    .push_data (tx_data_i),
    .pop       (tx_pop),
    .pop_data  (uart_tx_data_o),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level_o)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk       (clk),
    .reset_i   (reset_i),
    .push      (rx_push),
    .push_data (uart_rx_data_i),
    .pop       (rx_rd_i),
    .pop_data  (rx_data_o),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level_o)
  );

  assign tx_ready_o = !tx_full;
  assign rx_valid_o = !rx_empty;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_state_next;
      rx_state <= rx_state_next;
    end
  end

  // TX_HOLD covers the cycle before the UART's registered busy rises.
  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !uart_busy_i) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_HOLD;
        end
      end
      TX_HOLD: tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // RX_MASK skips the stale valid the UART still shows right after a read.
  always_comb begin
    rx_state_next = rx_state;
    rx_push       = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (uart_valid_i && !rx_full) begin
          rx_push       = 1'b1;
          rx_state_next = RX_MASK;
        end
      end
      RX_MASK: rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign uart_wr_o = tx_pop;
  assign uart_rd_o = rx_push;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomised and directed bench for uart_fifo_bridge against a queue-based reference model.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_i;
  logic [7:0]    tx_data_i;
  logic          tx_wr_i;
  logic          tx_ready_o;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          rx_rd_i;
  logic [LW-1:0] tx_level_o;
  logic [LW-1:0] rx_level_o;
  logic          uart_wr_o;
  logic [7:0]    uart_tx_data_o;
  logic          uart_busy_i;
  logic          uart_rd_o;
  logic [7:0]    uart_rx_data_i;
  logic          uart_valid_i;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .tx_data_i      (tx_data_i),
    .tx_wr_i        (tx_wr_i),
    .tx_ready_o     (tx_ready_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_rd_i        (rx_rd_i),
    .tx_level_o     (tx_level_o),
    .rx_level_o     (rx_level_o),
    .uart_wr_o      (uart_wr_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_busy_i    (uart_busy_i),
    .uart_rd_o      (uart_rd_o),
    .uart_rx_data_i (uart_rx_data_i),
    .uart_valid_i   (uart_valid_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: byte queues plus "strobe happened last cycle" flags.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_src[$];
  bit         last_wr;
  bit         rx_mask;
  bit         wr_seen;
  bit         rd_seen;
  bit         rd_d1;
  int         wr_pulses;
  int         rd_pulses;
  logic [7:0] last_pop;
  int         busy_mode;
  int         busy_len;
  int         busy_cnt;
  int         src_pct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit exp_wr;
    bit exp_rd;
    bit tx_acc;
    if (!reset_i) begin
      chk("rst_tx_ready", tx_ready_o, 1);
      chk("rst_rx_valid", rx_valid_o, 0);
      chk("rst_rx_data", rx_data_o, 0);
      chk("rst_uart_tx_data", uart_tx_data_o, 0);
      chk("rst_uart_wr", uart_wr_o, 0);
      chk("rst_uart_rd", uart_rd_o, 0);
      chk("rst_tx_level", tx_level_o, 0);
      chk("rst_rx_level", rx_level_o, 0);
      tx_q.delete();
      rx_q.delete();
      last_wr = 0;
      rx_mask = 0;
      wr_seen = 0;
      rd_seen = 0;
    end else begin
      exp_wr = (tx_q.size() > 0) && !uart_busy_i && !last_wr;
      exp_rd = !rx_mask && uart_valid_i && (rx_q.size() < DEPTH);
      chk("uart_wr", uart_wr_o, exp_wr);
      chk("uart_rd", uart_rd_o, exp_rd);
      chk("tx_level", tx_level_o, tx_q.size());
      chk("tx_ready", tx_ready_o, tx_q.size() < DEPTH);
      chk("uart_tx_data", uart_tx_data_o, (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'd0);
      chk("rx_level", rx_level_o, rx_q.size());
      chk("rx_valid", rx_valid_o, rx_q.size() > 0);
      chk("rx_data", rx_data_o, (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0);
      tx_acc = tx_wr_i && (tx_q.size() < DEPTH);
      if (exp_wr) void'(tx_q.pop_front());
      if (tx_acc) tx_q.push_back(tx_data_i);
      if (rx_rd_i && rx_q.size() > 0) last_pop = rx_q.pop_front();
      if (exp_rd) rx_q.push_back(uart_rx_data_i);
      if (uart_wr_o) wr_pulses++;
      if (uart_rd_o) rd_pulses++;
      last_wr = exp_wr;
      rx_mask = exp_rd;
      wr_seen = uart_wr_o;
      rd_seen = uart_rd_o;
    end
  end

  // Advance one cycle and update the UART-side model inputs for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (busy_mode == 1) begin
      uart_busy_i = 1'b1;
    end else begin
      if (wr_seen) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      uart_busy_i = (busy_cnt > 0);
    end
    if (uart_valid_i && rd_d1) uart_valid_i = 1'b0;
    rd_d1 = rd_seen;
    if (!uart_valid_i && rx_src.size() > 0 && $urandom_range(99) < src_pct) begin
      uart_valid_i   = 1'b1;
      uart_rx_data_i = rx_src.pop_front();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_i      = 1'b0;
    tx_wr_i      = 1'b0;
    rx_rd_i      = 1'b0;
    uart_valid_i = 1'b0;
    uart_busy_i  = 1'b0;
    rx_src.delete();
    busy_cnt  = 0;
    busy_mode = 0;
    rd_d1     = 0;
    #1;
    chk("async_rst_tx_level", tx_level_o, 0);
    chk("async_rst_rx_level", rx_level_o, 0);
    chk("async_rst_tx_ready", tx_ready_o, 1);
    chk("async_rst_rx_valid", rx_valid_o, 0);
    chk("async_rst_rx_data", rx_data_o, 0);
    chk("async_rst_uart_tx_data", uart_tx_data_o, 0);
    chk("async_rst_strobes", {uart_wr_o, uart_rd_o}, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    reset_i        = 1'b0;
    tx_data_i      = '0;
    tx_wr_i        = 1'b0;
    rx_rd_i        = 1'b0;
    uart_busy_i    = 1'b0;
    uart_rx_data_i = '0;
    uart_valid_i   = 1'b0;
    busy_mode = 0;
    busy_len  = 0;
    busy_cnt  = 0;
    src_pct   = 100;
    wr_pulses = 0;
    rd_pulses = 0;
    last_pop  = '0;
    rd_d1     = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;

    step();
    chk("idle_tx_ready", tx_ready_o, 1);
    chk("idle_rx_valid", rx_valid_o, 0);
    chk("idle_levels", {tx_level_o, rx_level_o}, 0);
    chk("idle_strobes", {uart_wr_o, uart_rd_o}, 0);

    // TX burst with a slow transmitter.
    busy_len  = 20;
    wr_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      tx_wr_i   = 1'b1;
      tx_data_i = 8'(8'h41 + i);
    end
    step();
    tx_wr_i = 1'b0;
    repeat (100) step();
    chk("burst_wr_pulses", wr_pulses, 3);
    chk("burst_tx_level", tx_level_o, 0);

    // TX full: transmitter stuck busy, two extra bytes dropped.
    busy_mode = 1;
    wr_pulses = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step();
      tx_wr_i   = 1'b1;
      tx_data_i = 8'($urandom);
    end
    step();
    tx_wr_i = 1'b0;
    chk("full_tx_ready", tx_ready_o, 0);
    chk("full_tx_level", tx_level_o, DEPTH);
    busy_mode = 0;
    busy_len  = 2;
    repeat (DEPTH * 4 + 10) step();
    chk("full_drain_pulses", wr_pulses, DEPTH);
    chk("full_drain_level", tx_level_o, 0);

    // RX single capture.
    rd_pulses = 0;
    rx_src.push_back(8'h5A);
    step();
    step();
    chk("cap_rx_valid", rx_valid_o, 1);
    chk("cap_rx_data", rx_data_o, 8'h5A);
    repeat (3) step();
    chk("cap_rd_pulses", rd_pulses, 1);
    rx_rd_i = 1'b1;
    step();
    rx_rd_i = 1'b0;
    chk("cap_pop_empty", rx_valid_o, 0);

    // RX full backpressure: 0x99 waits in the UART.
    rd_pulses = 0;
    for (int i = 0; i < DEPTH; i++) rx_src.push_back(8'($urandom));
    rx_src.push_back(8'h99);
    repeat (2 * DEPTH + 12) step();
    chk("rxfull_level", rx_level_o, DEPTH);
    chk("rxfull_rd_pulses", rd_pulses, DEPTH);
    chk("rxfull_byte_held", {uart_valid_i, uart_rx_data_i}, {1'b1, 8'h99});
    rx_rd_i = 1'b1;
    step();
    rx_rd_i = 1'b0;
    repeat (4) step();
    chk("rxfull_resume_level", rx_level_o, DEPTH);
    chk("rxfull_resume_pulses", rd_pulses, DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      rx_rd_i = 1'b1;
      step();
    end
    rx_rd_i = 1'b0;
    step();
    chk("rxfull_last_entry", last_pop, 8'h99);
    chk("rxfull_empty", rx_level_o, 0);

    // Reset in the middle of traffic.
    busy_mode = 1;
    for (int i = 0; i < 3; i++) rx_src.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      step();
      tx_wr_i   = 1'b1;
      tx_data_i = 8'($urandom);
    end
    step();
    tx_wr_i = 1'b0;
    repeat (8) step();
    chk("pre_rst_tx_level", tx_level_o, 5);
    chk("pre_rst_rx_level", rx_level_o, 3);
    do_reset();
    step();
    chk("post_rst_levels", {tx_level_o, rx_level_o}, 0);

    // Random traffic on both paths.
    src_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(15) == 0) busy_len = $urandom_range(4);
      tx_wr_i   = $urandom_range(1);
      tx_data_i = 8'($urandom);
      rx_rd_i   = ($urandom_range(99) < 35);
      if (rx_src.size() < 4) rx_src.push_back(8'($urandom));
    end
    tx_wr_i = 1'b0;
    rx_rd_i = 1'b1;
    rx_src.delete();
    repeat (200) step();
    chk("final_tx_level", tx_level_o, 0);
    chk("final_rx_level", rx_level_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
